// File: rtl/nibbler_pkg.sv
// nibbler_pkg: control-word bit positions and opcode encodings shared by the Nibbler control path
package nibbler_pkg;
  localparam int CTL_W = 13;
  localparam int CTL_INCPC = 12;
  localparam int CTL_LOADPC = 11;
  localparam int CTL_LOADFLAGS = 9;
  localparam logic [3:0] OP_JC = 4'h0;
  localparam logic [3:0] OP_JNC = 4'h1;
  localparam logic [3:0] OP_CMPI = 4'h2;
  localparam logic [3:0] OP_CMPM = 4'h3;
  localparam logic [3:0] OP_LIT = 4'h4;
  localparam logic [3:0] OP_IN = 4'h5;
  localparam logic [3:0] OP_OUT = 4'h6;
  localparam logic [3:0] OP_STORE = 4'h7;
  localparam logic [3:0] OP_JZ = 4'h8;
  localparam logic [3:0] OP_JNZ = 4'h9;
  localparam logic [3:0] OP_LOAD = 4'hA;
  localparam logic [3:0] OP_NORM = 4'hB;
  localparam logic [3:0] OP_JMP = 4'hC;
  localparam logic [3:0] OP_ADDI = 4'hD;
  localparam logic [3:0] OP_ADDM = 4'hE;
  localparam logic [3:0] OP_NANDM = 4'hF;
endpackage

// File: rtl/nibbler_pc.sv
// nibbler_pc: program counter with load/increment/hold, wrapping modulo 2^PC_W
module nibbler_pc #(
  parameter int PC_W = 12,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            inc,
  input  logic            load,
  input  logic [PC_W-1:0] target,
  output logic [PC_W-1:0] pc
);
  // load beats increment; the increment wraps silently at the top of the address space
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pc <= RESET_PC;
    else if (en) pc <= load ? target : inc ? pc + 1'b1 : pc;
endmodule

// File: rtl/nibbler_sequencer.sv
// nibbler_sequencer: phase, PC, IR and flag sequencing for the Nibbler control path
module nibbler_sequencer
  import nibbler_pkg::*;
#(
  parameter int PC_W = 12,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             step_en,
  input  logic [7:0]       rom_data,
  input  logic [CTL_W-1:0] control,
  input  logic             alu_carry,
  input  logic             alu_zero,
  output logic [PC_W-1:0]  pc,
  output logic [3:0]       opcode,
  output logic [3:0]       operand,
  output logic             phase,
  output logic             c_flag,
  output logic             z_flag,
  output logic             fetch_strobe
);
  logic [7:0] ir;
  logic pc_inc, pc_load;
  logic [PC_W-1:0] target;
  logic unused_ctl;
  assign opcode = ir[7:4];
  assign operand = ir[3:0];
  // fetch always advances even if control is not yet valid; jumps only happen in execute
  assign pc_inc = ~phase | control[CTL_INCPC];
  assign pc_load = phase & control[CTL_LOADPC];
  assign target = PC_W'({ir[3:0], rom_data});
  assign unused_ctl = ^{control[10], control[8:0]};
  nibbler_pc #(.PC_W(PC_W), .RESET_PC(RESET_PC)) u_pc (
    .clk(clk),
    .rst_n(rst_n),
    .en(step_en),
    .inc(pc_inc),
    .load(pc_load),
    .target(target),
    .pc(pc)
  );
  // phase toggles each enabled edge; fetch loads IR, execute optionally updates flags
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ir <= 8'h00;
      phase <= 1'b0;
      c_flag <= 1'b0;
      z_flag <= 1'b0;
      fetch_strobe <= 1'b0;
    end else if (step_en) begin
      phase <= ~phase;
      fetch_strobe <= ~phase;
      if (!phase) ir <= rom_data;
      if (phase && control[CTL_LOADFLAGS]) begin
        c_flag <= alu_carry;
        z_flag <= alu_zero;
      end
    end
endmodule
